// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding and IMEM geometry.
package imem_pkg;

   localparam int IMEM_ADDR_W    = 8;
   localparam int IMEM_MAX_WORDS = 64;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_CKSUM,
      ST_DONE,
      ST_ERR
   } state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: writes a header-prefixed program into big-endian byte IMEM and stalls the CPU.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte after the data bytes.
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDR_W    = IMEM_ADDR_W,
   parameter int MAX_WORDS = IMEM_MAX_WORDS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

`ifdef IMEM_LOADER_CKSUM_EN
   localparam state_t ST_AFTER_DATA = ST_CKSUM;
`else
   localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr_cnt;
   logic [ADDR_W-1:0] last_addr;
   logic              xfer;
   logic              restart;

   assign xfer    = in_valid & in_ready;
   assign restart = start & (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

`ifdef IMEM_LOADER_CKSUM_EN
   logic [7:0] cksum;

   // Running XOR over the header and every data byte; the trailing byte must match it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cksum <= '0;
      end else if (restart) begin
         cksum <= '0;
      end else if (xfer && (state == ST_HDR || state == ST_DATA)) begin
         cksum <= cksum ^ in_data;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_next = ST_HDR;
         end
         ST_HDR: begin
            in_ready = 1'b1;
            if (xfer) begin
               if (in_data > MAX_N)       state_next = ST_ERR;
               else if (in_data == 8'd0)  state_next = ST_AFTER_DATA;
               else                       state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            in_ready = 1'b1;
            if (xfer && addr_cnt == last_addr) state_next = ST_AFTER_DATA;
         end
`ifdef IMEM_LOADER_CKSUM_EN
         ST_CKSUM: begin
            in_ready = 1'b1;
            if (xfer) state_next = (in_data == cksum) ? ST_DONE : ST_ERR;
         end
`endif
         ST_DONE, ST_ERR: begin
            if (start) state_next = ST_HDR;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Write port, address counter and status flags. Status settles one cycle after
   // entering DONE/ERR so LOAD_DONE never overlaps the final write strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         addr_cnt  <= '0;
         last_addr <= '0;
         cpu_hold  <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         wr_en <= 1'b0;

         if (restart) begin
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            addr_cnt  <= '0;
         end else if (state == ST_DONE) begin
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
         end else if (state == ST_ERR) begin
            load_err  <= 1'b1;
            cpu_hold  <= 1'b0;
         end

         if (xfer && state == ST_HDR) begin
            last_addr <= ADDR_W'(32'(in_data) * BYTES_PER_WORD - 1);
         end

         if (xfer && state == ST_DATA) begin
            wr_en   <= 1'b1;
            wr_addr <= addr_cnt;
            wr_data <= in_data;
            if (addr_cnt != last_addr) addr_cnt <= addr_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: transaction-level model of each load, per-cycle write checker.
// Build with +define+IMEM_LOADER_CKSUM_EN to exercise the checksum variant.
module tb_imem_loader;

`ifdef IMEM_LOADER_CKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       cpu_hold;
   logic       load_done;
   logic       load_err;

   imem_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   int         vectors = 0;
   int         miscompares = 0;
   int         edge_cnt = 0;
   wr_t        exp_q[$];
   logic [7:0] stream[$];
   logic [7:0] imem[256];

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every write the model predicts must appear on exactly its cycle, and nothing else may be written.
   always @(negedge clk) begin
      if (rst_n) begin
         logic exp_wr;
         exp_wr = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
         check("wr_en", {31'b0, wr_en}, {31'b0, exp_wr});
         if (exp_wr) begin
            check("wr_addr", {24'b0, wr_addr}, {24'b0, exp_q[0].addr});
            check("wr_data", {24'b0, wr_data}, {24'b0, exp_q[0].data});
            void'(exp_q.pop_front());
         end
         if (wr_en) imem[wr_addr] = wr_data;
      end
   end

   function automatic logic [7:0] xor_of(input int upto);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < upto; i++) x ^= stream[i];
      return x;
   endfunction

   // Builds stream = header N, then 4N random bytes, then (checksum build only) the XOR byte ^ flip.
   task automatic make_stream(input int n, input logic [7:0] flip);
      stream.delete();
      stream.push_back(8'(n));
      if (n <= 64) for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
      if (CK_EN && n <= 64) stream.push_back(xor_of(stream.size()) ^ flip);
   endtask

   // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
   // start_at: byte index during which START is re-pulsed (-1 none).
   // abort_at: after this many accepted bytes, pull reset (-1 none).
   task automatic do_load(input int gap_mode, input int start_at, input int abort_at);
      int   n, nacc, idx, cyc;
      bit   exp_err, valid;
      n = int'(stream[0]);
      if (n > 64) begin
         nacc    = 1;
         exp_err = 1'b1;
      end else begin
         nacc    = 1 + 4 * n + (CK_EN ? 1 : 0);
         exp_err = CK_EN && (stream[4 * n + 1] != xor_of(4 * n + 1));
      end

      @(posedge clk); #2;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;

      idx = 0;
      cyc = 0;
      while (idx < nacc) begin
         if (idx == abort_at) break;
         check("in_ready_busy", {31'b0, in_ready}, 32'd1);
         check("cpu_hold_busy", {31'b0, cpu_hold}, 32'd1);
         case (gap_mode)
            0:       valid = 1'b1;
            1:       valid = cyc[0];
            default: valid = ($urandom_range(0, 2) != 0);
         endcase
         in_valid = valid;
         in_data  = valid ? stream[idx] : 8'($urandom);
         start    = valid && (idx == start_at);
         if (valid && idx >= 1 && idx <= 4 * n && n <= 64)
            exp_q.push_back('{due: edge_cnt + 1, addr: 8'(idx - 1), data: stream[idx]});
         @(posedge clk); #2;
         start = 1'b0;
         if (valid) idx++;
         cyc++;
      end
      in_valid = 1'b0;

      if (abort_at >= 0) begin
         @(posedge clk); #2;
         rst_n = 1'b0;
         #1;
         check("rst_in_ready",  {31'b0, in_ready},  32'd0);
         check("rst_wr_en",     {31'b0, wr_en},     32'd0);
         check("rst_wr_addr",   {24'b0, wr_addr},   32'd0);
         check("rst_wr_data",   {24'b0, wr_data},   32'd0);
         check("rst_cpu_hold",  {31'b0, cpu_hold},  32'd0);
         check("rst_load_done", {31'b0, load_done}, 32'd0);
         check("rst_load_err",  {31'b0, load_err},  32'd0);
         check("rst_pending",   exp_q.size(), 32'd0);
         exp_q.delete();
         #1 rst_n = 1'b1;
         return;
      end

      // Cycle of the final accepted byte: nothing reported yet, CPU still held.
      check("hold_last",  {31'b0, cpu_hold},  32'd1);
      check("done_early", {31'b0, load_done}, 32'd0);
      check("err_early",  {31'b0, load_err},  32'd0);
      @(posedge clk); #2;
      check("load_done",  {31'b0, load_done}, {31'b0, !exp_err});
      check("load_err",   {31'b0, load_err},  {31'b0, exp_err});
      check("cpu_hold",   {31'b0, cpu_hold},  32'd0);
      check("ready_idle", {31'b0, in_ready},  32'd0);

      // Bytes offered after the load must be refused and never written.
      in_valid = 1'b1;
      in_data  = 8'hEE;
      repeat (3) @(posedge clk);
      #2 in_valid = 1'b0;
      check("ready_after", {31'b0, in_ready}, 32'd0);
      check("pending_writes", exp_q.size(), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      for (int i = 0; i < 256; i++) imem[i] = 8'h00;

      #3;
      check("reset_in_ready",  {31'b0, in_ready},  32'd0);
      check("reset_wr_en",     {31'b0, wr_en},     32'd0);
      check("reset_wr_addr",   {24'b0, wr_addr},   32'd0);
      check("reset_wr_data",   {24'b0, wr_data},   32'd0);
      check("reset_cpu_hold",  {31'b0, cpu_hold},  32'd0);
      check("reset_load_done", {31'b0, load_done}, 32'd0);
      check("reset_load_err",  {31'b0, load_err},  32'd0);
      #9 rst_n = 1'b1;

      // Three-instruction program, back-to-back then every other cycle.
      stream = '{8'h03, 8'h20, 8'h09, 8'h00, 8'h04, 8'h20, 8'h0B, 8'h00, 8'h05,
                 8'h01, 8'h2B, 8'h50, 8'h20};
      check("cksum_model", {24'b0, xor_of(13)}, 32'h0000_005A);
      if (CK_EN) stream.push_back(8'h5A);
      do_load(0, -1, -1);
      check("fetch_pc0", {imem[0], imem[1], imem[2], imem[3]},   32'h2009_0004);
      check("fetch_pc8", {imem[8], imem[9], imem[10], imem[11]}, 32'h012B_5020);
      for (int i = 0; i < 12; i++) imem[i] = 8'h00;
      do_load(1, -1, -1);
      check("fetch_pc4_gap", {imem[4], imem[5], imem[6], imem[7]}, 32'h200B_0005);

      // Corrupted checksum: data still written, load reported as aborted.
      if (CK_EN) begin
         stream[13] = 8'h5B;
         do_load(0, -1, -1);
      end

      // Oversized header: rejected with no writes.
      make_stream(65, 8'h00);
      do_load(0, -1, -1);
      make_stream(255, 8'h00);
      do_load(2, -1, -1);

      // Reset after 5 data bytes, then a fresh load succeeds.
      make_stream(3, 8'h00);
      do_load(0, -1, 6);
      make_stream(3, 8'h00);
      do_load(0, -1, -1);

      // START inside DATA is ignored; empty program completes with no writes.
      make_stream(4, 8'h00);
      do_load(2, 7, -1);
      make_stream(0, 8'h00);
      do_load(0, -1, -1);

      // Boundary: largest legal program, back-to-back.
      make_stream(64, 8'h00);
      do_load(0, -1, -1);
      check("fetch_top", {imem[252], imem[253], imem[254], imem[255]},
            {stream[253], stream[254], stream[255], stream[256]});

      // Randomized loads with random gaps, sizes, stray STARTs and checksum faults.
      for (int r = 0; r < 12; r++) begin
         int n;
         case ($urandom_range(0, 5))
            0:       n = 0;
            1:       n = $urandom_range(65, 255);
            2:       n = 64;
            default: n = $urandom_range(1, 10);
         endcase
         make_stream(n, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
         do_load(2, (n > 0 && n <= 64) ? $urandom_range(1, 4 * n) : -1, -1);
      end

      repeat (4) @(posedge clk);
      #2 check("final_pending", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
